rr_stream_mux: RTL

- Parametrised N-channel, W-bit stream multiplexer; successor to the combinational 8:1 mux.
- Adds valid/ready handshaking on every input and the output, plus a registered output stage.
- Two selection modes: fixed select (legacy mux behaviour) and round-robin arbitration.
- Sits between several producer datapaths and one shared consumer, e.g. a display or UART transmitter.

---
 rtl/rr_stream_mux_pkg.sv | 14 +
 rtl/rr_stream_mux_rr_arbiter.sv | 33 +++
 rtl/rr_stream_mux.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: picks the first requester at or above ptr, wrapping modulo N_CH.
module rr_stream_mux_rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int                 w_j;
    logic [SEL_W-1:0]   w_idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_j       = 0;
        w_idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_j = int'(ptr) + i;
            if (w_j >= N_CH) w_j = w_j - N_CH;
            w_idx = SEL_W'(w_j);
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant and a registered output.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_ch
);

    logic [W-1:0]      r_out_data;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load_en;
    logic              w_fix_valid;
    logic [SEL_W-1:0]  w_rr_idx;
    logic              w_rr_valid;
    logic [SEL_W-1:0]  w_grant;
    logic              w_granted;
    logic              w_xfer;
    logic [W-1:0]      w_gnt_data;
    logic [N_CH-1:0]   w_in_ready;

    rr_stream_mux_rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .gnt_idx   (w_rr_idx),
        .gnt_valid (w_rr_valid)
    );

    assign w_load_en = !r_out_valid || out_ready;

    // Out-of-range sel matches no channel, so it never grants.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) w_fix_valid = in_valid[k];
        end
    end

    assign w_grant   = (mode == MODE_RR) ? w_rr_idx : sel;
    assign w_granted = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_xfer    = w_load_en && w_granted;

    always_comb begin
        w_gnt_data = '0;
        w_in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_gnt_data    = in_data[k*W +: W];
                w_in_ready[k] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_grant;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= (w_grant == SEL_W'(N_CH - 1)) ? '0 : w_grant + SEL_W'(1);
                end
            end else if (w_load_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule
